// File: rtl/cpu_core.sv
// Accumulator CPU: two-cycle FETCH/EXEC machine with a 16-opcode set and an
// unreset internal word memory that is preloaded hierarchically before reset release.
module cpu_core #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 48
) (
    input logic clk,
    input logic reset
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] ir;
    state_t                state;
    logic                  halted;
    logic                  retire;

    logic [3:0]            opcode;
    logic [11:0]           field_a;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [WORD_WIDTH-1:0] operand;
    logic [WORD_WIDTH-1:0] field_a_ext;
    logic                  unused_ok;

    assign opcode      = ir[15:12];
    assign field_a     = ir[11:0];
    assign op_addr     = ADDR_WIDTH'(field_a);
    assign field_a_ext = WORD_WIDTH'(field_a);
    // Operand read is combinational so EXEC sees a store from the previous instruction.
    assign operand     = mem[op_addr];
    // Upper ir bits and the trace flags are observed only from outside the block.
    assign unused_ok   = ^{ir[WORD_WIDTH-1:16], halted, retire};

    // Only EXEC writes; reset forces FETCH asynchronously, so an aborted STA never lands.
    always_ff @(posedge clk) begin
        if (state == EXEC && opcode == 4'h2) begin
            mem[op_addr] <= acc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            acc    <= '0;
            ir     <= '0;
            state  <= FETCH;
            halted <= 1'b0;
            retire <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir     <= mem[pc];
                    pc     <= pc + ADDR_WIDTH'(1);
                    state  <= EXEC;
                    retire <= 1'b1;
                end
                EXEC: begin
                    retire <= 1'b0;
                    state  <= FETCH;
                    case (opcode)
                        4'h1: acc <= operand;
                        4'h3: acc <= acc + operand;
                        4'h4: acc <= acc - operand;
                        4'h5: acc <= acc & operand;
                        4'h6: acc <= acc | operand;
                        4'h7: acc <= acc ^ operand;
                        4'h8: pc  <= op_addr;
                        4'h9: if (acc == '0) pc <= op_addr;
                        4'hA: if (acc[WORD_WIDTH-1]) pc <= op_addr;
                        4'hB: acc <= field_a_ext;
                        4'hC: acc <= acc << 1;
                        4'hD: acc <= acc >> 1;
                        4'hF: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT: begin
                    retire <= 1'b0;
                    halted <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed program tests for cpu_core: programs are preloaded into mem under reset
// and architectural state is compared against hand-computed values.
module tb_cpu_core;

    logic clk;
    logic reset;

    int errors      = 0;
    int checks      = 0;
    int retire_seen = 0;

    cpu_core #(.ADDR_WIDTH(12), .WORD_WIDTH(48)) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dut.retire) retire_seen++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s: got %h ok", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4096; i++) dut.mem[i] = '0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [47:0] alu_acc [15];
    logic [11:0] alu_pc  [15];
    logic [63:0] frz_pc, frz_acc, frz_ir, frz_m17;

    initial begin
        // Program 1: LDI 5; ADD [16]; STA [17]; HALT
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) dut.mem[i] = '0;
        dut.mem[0]  = 48'hB005;
        dut.mem[1]  = 48'h3010;
        dut.mem[2]  = 48'h2011;
        dut.mem[3]  = 48'hF000;
        dut.mem[16] = 48'd7;
        #100;
        check("rst_pc", 64'(dut.pc), 64'h0);
        check("rst_acc", 64'(dut.acc), 64'h0);
        check("rst_ir", 64'(dut.ir), 64'h0);
        check("rst_state", 64'(dut.state), 64'h0);
        check("rst_halted", 64'(dut.halted), 64'h0);
        check("rst_retire", 64'(dut.retire), 64'h0);
        leave_reset();
        retire_seen = 0;
        step(1);
        check("first_fetch_ir", 64'(dut.ir), 64'hB005);
        check("first_fetch_pc", 64'(dut.pc), 64'h1);
        check("retire_in_exec", 64'(dut.retire), 64'h1);
        step(6);
        check("p1_not_halted_c7", 64'(dut.halted), 64'h0);
        step(1);
        check("p1_halted_c8", 64'(dut.halted), 64'h1);
        check("p1_acc", 64'(dut.acc), 64'd12);
        check("p1_mem17", 64'(dut.mem[17]), 64'd12);
        check("p1_retires", 64'(retire_seen), 64'd4);

        // Halt freeze over 1000 cycles
        frz_pc = 64'(dut.pc); frz_acc = 64'(dut.acc);
        frz_ir = 64'(dut.ir); frz_m17 = 64'(dut.mem[17]);
        retire_seen = 0;
        step(1000);
        check("halt_retires", 64'(retire_seen), 64'd0);
        check("halt_pc", 64'(dut.pc), 64'h4);
        check("halt_pc_frozen", 64'(dut.pc), frz_pc);
        check("halt_acc_frozen", 64'(dut.acc), frz_acc);
        check("halt_ir_frozen", 64'(dut.ir), frz_ir);
        check("halt_mem_frozen", 64'(dut.mem[17]), frz_m17);
        check("halt_state", 64'(dut.state), 64'h2);
        check("halt_flag", 64'(dut.halted), 64'h1);

        // JZ taken: LDI 0; JZ 0x020
        enter_reset();
        dut.mem[0] = 48'hB000; dut.mem[1] = 48'h9020; dut.mem[12'h020] = 48'hF000;
        leave_reset();
        step(4);
        check("jz_taken_pc", 64'(dut.pc), 64'h020);

        // JZ untaken: LDI 1; JZ 0x020
        enter_reset();
        dut.mem[0] = 48'hB001; dut.mem[1] = 48'h9020; dut.mem[2] = 48'hF000;
        dut.mem[12'h020] = 48'hF000;
        leave_reset();
        step(4);
        check("jz_untaken_pc", 64'(dut.pc), 64'h2);
        step(2);
        check("jz_untaken_halt", 64'(dut.halted), 64'h1);
        check("jz_untaken_pc_end", 64'(dut.pc), 64'h3);

        // Negative result: LDI FFF; STA 30; LDI 0; SUB [30]; JN 010; (010) SHR; HALT
        enter_reset();
        dut.mem[0] = 48'hBFFF; dut.mem[1] = 48'h2030; dut.mem[2] = 48'hB000;
        dut.mem[3] = 48'h4030; dut.mem[4] = 48'hA010; dut.mem[5] = 48'hF000;
        dut.mem[12'h010] = 48'hD000; dut.mem[12'h011] = 48'hF000;
        leave_reset();
        step(8);
        check("sub_acc", 64'(dut.acc), 64'h0000_FFFF_FFFF_F001);
        step(2);
        check("jn_taken_pc", 64'(dut.pc), 64'h010);
        step(2);
        check("shr_acc", 64'(dut.acc), 64'h0000_7FFF_FFFF_F800);
        step(2);
        check("neg_halt", 64'(dut.halted), 64'h1);
        check("neg_sta_mem", 64'(dut.mem[12'h030]), 64'hFFF);

        // ALU / branch / store-load sequence checked after every instruction
        enter_reset();
        dut.mem[12'h040] = 48'h0000_0000_FF0F;
        dut.mem[12'h041] = 48'h0000_0000_0FF0;
        dut.mem[12'h042] = 48'hFFFF_FFFF_FFFF;
        dut.mem[0] = 48'h1040; dut.mem[1] = 48'h5041; dut.mem[2] = 48'h6040;
        dut.mem[3] = 48'h7041; dut.mem[4] = 48'hC000; dut.mem[5] = 48'h3042;
        dut.mem[6] = 48'hE123; dut.mem[7] = 48'h0000; dut.mem[8] = 48'h8100;
        dut.mem[12'h100] = 48'hA200; dut.mem[12'h101] = 48'h9200;
        dut.mem[12'h102] = 48'h2043; dut.mem[12'h103] = 48'h1043;
        dut.mem[12'h104] = 48'hABCD_0000_B123; dut.mem[12'h105] = 48'hF000;
        alu_acc = '{48'hFF0F, 48'h0F00, 48'hFF0F, 48'hF0FF, 48'h1E1FE, 48'h1E1FD,
                    48'h1E1FD, 48'h1E1FD, 48'h1E1FD, 48'h1E1FD, 48'h1E1FD,
                    48'h1E1FD, 48'h1E1FD, 48'h123, 48'h123};
        alu_pc  = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007,
                    12'h008, 12'h100, 12'h101, 12'h102, 12'h103, 12'h104,
                    12'h105, 12'h106};
        leave_reset();
        for (int k = 0; k < 15; k++) begin
            step(2);
            check($sformatf("alu%0d_acc", k), 64'(dut.acc), 64'(alu_acc[k]));
            check($sformatf("alu%0d_pc", k), 64'(dut.pc), 64'(alu_pc[k]));
        end
        check("alu_sta_mem", 64'(dut.mem[12'h043]), 64'h1E1FD);
        check("alu_halt", 64'(dut.halted), 64'h1);

        // pc wrap: JMP FFF; NOP at FFF; next fetch comes from 0
        enter_reset();
        dut.mem[0] = 48'h8FFF; dut.mem[12'hFFF] = 48'h0000;
        leave_reset();
        step(2);
        check("wrap_jmp_pc", 64'(dut.pc), 64'hFFF);
        step(1);
        check("wrap_pc", 64'(dut.pc), 64'h000);
        step(2);
        check("wrap_refetch_ir", 64'(dut.ir), 64'h8FFF);

        // Self-modifying: LDA [10] (=HALT word); STA 2 overwrites LDI
        enter_reset();
        dut.mem[0] = 48'h1010; dut.mem[1] = 48'h2002; dut.mem[2] = 48'hB0AA;
        dut.mem[3] = 48'hF000; dut.mem[12'h010] = 48'hF000;
        leave_reset();
        step(6);
        check("smc_halted", 64'(dut.halted), 64'h1);
        check("smc_acc", 64'(dut.acc), 64'hF000);

        // Reset during EXEC of STA
        enter_reset();
        dut.mem[0] = 48'hB077; dut.mem[1] = 48'h2050; dut.mem[12'h050] = 48'h1234;
        leave_reset();
        step(3);
        check("abort_in_exec", 64'(dut.state), 64'h1);
        reset = 1'b1;
        #1;
        check("abort_pc", 64'(dut.pc), 64'h0);
        check("abort_acc", 64'(dut.acc), 64'h0);
        check("abort_state", 64'(dut.state), 64'h0);
        check("abort_retire", 64'(dut.retire), 64'h0);
        step(2);
        check("abort_mem_kept", 64'(dut.mem[12'h050]), 64'h1234);
        check("abort_pc_held", 64'(dut.pc), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
